// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator producing sync, blanking, scan position and strobes.
// Latency: h_cnt/v_cnt are raw; HS, VS, blank_n, x, y, line_start, frame_start lag them by PIPE_DLY pix_en edges.
// Backpressure: none; pix_en gates every state update and all state holds while it is low.
// Ports: vga_clk (all logic on its falling edge), reset_n (synchronous, active-low), pix_en (pixel enable);
//        outputs HS, VS, blank_n, raw counters h_cnt/v_cnt, visible coordinates x/y, line_start, frame_start.
`timescale 1ns/1ps
module vga_timing_gen #(
   parameter int   H_VISIBLE  = 640,
   parameter int   H_FRONT    = 16,
   parameter int   H_SYNC     = 96,
   parameter int   H_BACK     = 48,
   parameter int   V_VISIBLE  = 480,
   parameter int   V_FRONT    = 10,
   parameter int   V_SYNC     = 2,
   parameter int   V_BACK     = 33,
   parameter logic H_SYNC_POL = 1'b0,
   parameter logic V_SYNC_POL = 1'b0,
   parameter int   PIPE_DLY   = 1,
   parameter int   CW_H       = 11,
   parameter int   CW_V       = 10
) (
   input  logic            vga_clk,
   input  logic            reset_n,
   input  logic            pix_en,
   output logic            HS,
   output logic            VS,
   output logic            blank_n,
   output logic [CW_H-1:0] h_cnt,
   output logic [CW_V-1:0] v_cnt,
   output logic [CW_H-1:0] x,
   output logic [CW_V-1:0] y,
   output logic            line_start,
   output logic            frame_start
);

   localparam int H_TOTAL = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;

   localparam logic [CW_H-1:0] H_LAST     = CW_H'(H_TOTAL - 1);
   localparam logic [CW_H-1:0] H_SYNC_END = CW_H'(H_SYNC);
   localparam logic [CW_H-1:0] H_VIS_BEG  = CW_H'(H_SYNC + H_BACK);
   localparam logic [CW_H-1:0] H_VIS_END  = CW_H'(H_TOTAL - H_FRONT);
   localparam logic [CW_V-1:0] V_LAST     = CW_V'(V_TOTAL - 1);
   localparam logic [CW_V-1:0] V_SYNC_END = CW_V'(V_SYNC);
   localparam logic [CW_V-1:0] V_VIS_BEG  = CW_V'(V_SYNC + V_BACK);
   localparam logic [CW_V-1:0] V_VIS_END  = CW_V'(V_TOTAL - V_FRONT);

   // One slot of the output delay line: everything derived from a scan position.
   typedef struct packed {
      logic            hs;
      logic            vs;
      logic            blank_n;
      logic [CW_H-1:0] x;
      logic [CW_V-1:0] y;
      logic            h0;
      logic            v0;
   } stage_t;

   // Inactive values; h0/v0 cleared so a freshly reset line never fires a strobe.
   localparam stage_t STAGE_IDLE = '{hs: ~H_SYNC_POL, vs: ~V_SYNC_POL, blank_n: 1'b0,
                                     x: '0, y: '0, h0: 1'b0, v0: 1'b0};

   logic [CW_H-1:0] h_cnt_q, h_cnt_d;
   logic [CW_V-1:0] v_cnt_q, v_cnt_d;
   logic            adv_q, adv_d;       // last edge advanced the raster
   logic            h_vis, v_vis;
   stage_t          pos_stage;
   stage_t          out_stage;

   // Scan counters; v steps only on the h wrap, so (last,last) goes to (0,0) in one edge.
   always_comb begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      adv_d   = pix_en;
      if (pix_en) begin
         if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
         end else begin
            h_cnt_d = h_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(negedge vga_clk) begin
      if (!reset_n) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
         adv_q   <= 1'b0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         adv_q   <= adv_d;
      end
   end

   // Decode of the current counter position.
   always_comb begin
      h_vis             = (h_cnt_q >= H_VIS_BEG) && (h_cnt_q < H_VIS_END);
      v_vis             = (v_cnt_q >= V_VIS_BEG) && (v_cnt_q < V_VIS_END);
      pos_stage         = STAGE_IDLE;
      pos_stage.hs      = (h_cnt_q < H_SYNC_END) ? H_SYNC_POL : ~H_SYNC_POL;
      pos_stage.vs      = (v_cnt_q < V_SYNC_END) ? V_SYNC_POL : ~V_SYNC_POL;
      pos_stage.blank_n = h_vis && v_vis;
      pos_stage.x       = pos_stage.blank_n ? h_cnt_q - H_VIS_BEG : '0;
      pos_stage.y       = pos_stage.blank_n ? v_cnt_q - V_VIS_BEG : '0;
      pos_stage.h0      = (h_cnt_q == '0);
      pos_stage.v0      = (v_cnt_q == '0);
   end

   generate
      if (PIPE_DLY == 0) begin : g_comb
         assign out_stage = pos_stage;
      end else begin : g_pipe
         stage_t pipe_q [PIPE_DLY];
         stage_t pipe_d [PIPE_DLY];

         always_comb begin
            for (int i = 0; i < PIPE_DLY; i++) pipe_d[i] = pipe_q[i];
            if (pix_en) begin
               pipe_d[0] = pos_stage;
               for (int i = 1; i < PIPE_DLY; i++) pipe_d[i] = pipe_q[i-1];
            end
         end

         always_ff @(negedge vga_clk) begin
            if (!reset_n) begin
               for (int i = 0; i < PIPE_DLY; i++) pipe_q[i] <= STAGE_IDLE;
            end else begin
               for (int i = 0; i < PIPE_DLY; i++) pipe_q[i] <= pipe_d[i];
            end
         end

         assign out_stage = pipe_q[PIPE_DLY-1];
      end
   endgenerate

   assign HS      = out_stage.hs;
   assign VS      = out_stage.vs;
   assign blank_n = out_stage.blank_n;
   assign x       = out_stage.x;
   assign y       = out_stage.y;
   assign h_cnt   = h_cnt_q;
   assign v_cnt   = v_cnt_q;

   // Strobes fire only in the cycle right after an enabled edge, so a held position never repeats them.
   assign line_start  = adv_q & out_stage.h0;
   assign frame_start = adv_q & out_stage.h0 & out_stage.v0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks three vga_timing_gen configurations against a position-history model.
// dut0 = 640x480 defaults (PIPE_DLY 1), dut1 = tiny 8x4 raster (PIPE_DLY 0), dut2 = 800x600 positive sync (PIPE_DLY 3).
// Stimulus pushes expected outputs into a scoreboard queue; a monitor pops one entry per clock and compares.
`timescale 1ns/1ps
module tb_vga_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst0, en0, rst1, en1, rst2, en2;
   logic hs0, vs0, bl0, ls0, fs0;
   logic hs1, vs1, bl1, ls1, fs1;
   logic hs2, vs2, bl2, ls2, fs2;
   logic [10:0] hc0, x0;
   logic [9:0]  vc0, y0;
   logic [4:0]  hc1, x1;
   logic [3:0]  vc1, y1;
   logic [10:0] hc2, x2;
   logic [9:0]  vc2, y2;

   vga_timing_gen u_def (
      .vga_clk(clk), .reset_n(rst0), .pix_en(en0),
      .HS(hs0), .VS(vs0), .blank_n(bl0), .h_cnt(hc0), .v_cnt(vc0),
      .x(x0), .y(y0), .line_start(ls0), .frame_start(fs0)
   );

   vga_timing_gen #(
      .H_VISIBLE(8), .H_FRONT(3), .H_SYNC(2), .H_BACK(3),
      .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
      .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .PIPE_DLY(0), .CW_H(5), .CW_V(4)
   ) u_sml (
      .vga_clk(clk), .reset_n(rst1), .pix_en(en1),
      .HS(hs1), .VS(vs1), .blank_n(bl1), .h_cnt(hc1), .v_cnt(vc1),
      .x(x1), .y(y1), .line_start(ls1), .frame_start(fs1)
   );

   vga_timing_gen #(
      .H_VISIBLE(800), .H_FRONT(40), .H_SYNC(128), .H_BACK(88),
      .V_VISIBLE(600), .V_FRONT(1), .V_SYNC(4), .V_BACK(23),
      .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .PIPE_DLY(3), .CW_H(11), .CW_V(10)
   ) u_svga (
      .vga_clk(clk), .reset_n(rst2), .pix_en(en2),
      .HS(hs2), .VS(vs2), .blank_n(bl2), .h_cnt(hc2), .v_cnt(vc2),
      .x(x2), .y(y2), .line_start(ls2), .frame_start(fs2)
   );

   // Configuration of each instance, indexed by dut number.
   int P_HV [3] = '{640, 8, 800};
   int P_HF [3] = '{16, 3, 40};
   int P_HS [3] = '{96, 2, 128};
   int P_HB [3] = '{48, 3, 88};
   int P_VV [3] = '{480, 4, 600};
   int P_VF [3] = '{10, 1, 1};
   int P_VS [3] = '{2, 2, 4};
   int P_VB [3] = '{33, 2, 23};
   bit P_HPOL [3] = '{1'b0, 1'b0, 1'b1};
   bit P_VPOL [3] = '{1'b0, 1'b0, 1'b1};
   int P_DLY [3] = '{1, 0, 3};

   typedef struct {
      int sel;
      bit win;
      bit hs, vs, bl, ls, fs;
      int h, v, x, y;
   } exp_t;

   exp_t sb[$];

   // Model state: counters plus a history of the positions loaded on enabled edges.
   int mh [3];
   int mv [3];
   bit adv [3];
   int ph [3][8];
   int pv [3][8];
   bit pok [3][8];

   int nvec  = 0;
   int nfail = 0;
   int acc_hs, acc_vs, acc_bl, acc_ls, acc_fs, acc_xmax, acc_ymax;

   function automatic exp_t model_out(int s);
      exp_t o;
      int   h, v, ht, vt, d;
      bit   ok, hvis, vvis;
      d = P_DLY[s];
      if (d == 0) begin
         h = mh[s]; v = mv[s]; ok = 1'b1;
      end else begin
         h = ph[s][d-1]; v = pv[s][d-1]; ok = pok[s][d-1];
      end
      ht = P_HS[s] + P_HB[s] + P_HV[s] + P_HF[s];
      vt = P_VS[s] + P_VB[s] + P_VV[s] + P_VF[s];
      o.sel = s; o.win = 1'b0; o.h = mh[s]; o.v = mv[s];
      o.hs = !P_HPOL[s]; o.vs = !P_VPOL[s]; o.bl = 1'b0;
      o.x = 0; o.y = 0; o.ls = 1'b0; o.fs = 1'b0;
      if (ok) begin
         if (h < P_HS[s]) o.hs = P_HPOL[s];
         if (v < P_VS[s]) o.vs = P_VPOL[s];
         hvis = (h >= P_HS[s] + P_HB[s]) && (h < ht - P_HF[s]);
         vvis = (v >= P_VS[s] + P_VB[s]) && (v < vt - P_VF[s]);
         o.bl = hvis && vvis;
         if (o.bl) begin
            o.x = h - (P_HS[s] + P_HB[s]);
            o.y = v - (P_VS[s] + P_VB[s]);
         end
         o.ls = adv[s] && (h == 0);
         o.fs = o.ls && (v == 0);
      end
      return o;
   endfunction

   function automatic exp_t observe(int s);
      exp_t o;
      o.sel = s; o.win = 1'b0;
      o.hs = 1'b0; o.vs = 1'b0; o.bl = 1'b0; o.ls = 1'b0; o.fs = 1'b0;
      o.h = 0; o.v = 0; o.x = 0; o.y = 0;
      case (s)
         0: begin
            o.hs = hs0; o.vs = vs0; o.bl = bl0; o.ls = ls0; o.fs = fs0;
            o.h = int'(hc0); o.v = int'(vc0); o.x = int'(x0); o.y = int'(y0);
         end
         1: begin
            o.hs = hs1; o.vs = vs1; o.bl = bl1; o.ls = ls1; o.fs = fs1;
            o.h = int'(hc1); o.v = int'(vc1); o.x = int'(x1); o.y = int'(y1);
         end
         default: begin
            o.hs = hs2; o.vs = vs2; o.bl = bl2; o.ls = ls2; o.fs = fs2;
            o.h = int'(hc2); o.v = int'(vc2); o.x = int'(x2); o.y = int'(y2);
         end
      endcase
      return o;
   endfunction

   // One clock of stimulus for dut s; the expected outputs after the coming negedge go to the scoreboard.
   task automatic step(input int s, input bit r, input bit e, input bit w);
      exp_t o;
      int   ht, vt;
      @(posedge clk);
      #1;
      case (s)
         0: begin rst0 = r; en0 = e; end
         1: begin rst1 = r; en1 = e; end
         default: begin rst2 = r; en2 = e; end
      endcase
      ht = P_HS[s] + P_HB[s] + P_HV[s] + P_HF[s];
      vt = P_VS[s] + P_VB[s] + P_VV[s] + P_VF[s];
      if (!r) begin
         mh[s] = 0; mv[s] = 0; adv[s] = 1'b0;
         for (int k = 0; k < 8; k++) pok[s][k] = 1'b0;
      end else begin
         adv[s] = e;
         if (e) begin
            for (int k = 7; k > 0; k--) begin
               ph[s][k] = ph[s][k-1]; pv[s][k] = pv[s][k-1]; pok[s][k] = pok[s][k-1];
            end
            ph[s][0] = mh[s]; pv[s][0] = mv[s]; pok[s][0] = 1'b1;
            if (mh[s] == ht - 1) begin
               mh[s] = 0;
               mv[s] = (mv[s] == vt - 1) ? 0 : mv[s] + 1;
            end else begin
               mh[s] = mh[s] + 1;
            end
         end
      end
      o = model_out(s);
      o.win = w;
      sb.push_back(o);
   endtask

   task automatic chk(input string name, input int got, input int exp_v);
      nvec++;
      if (got != exp_v) begin
         nfail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp_v);
      end
   endtask

   task automatic clr();
      acc_hs = 0; acc_vs = 0; acc_bl = 0; acc_ls = 0; acc_fs = 0;
      acc_xmax = 0; acc_ymax = 0;
   endtask

   // Monitor: one scoreboard entry per rising edge, half a period after the DUT's active edge.
   initial begin : monitor
      exp_t e, g;
      forever begin
         @(posedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            g = observe(e.sel);
            nvec++;
            if (g.hs != e.hs || g.vs != e.vs || g.bl != e.bl || g.ls != e.ls || g.fs != e.fs ||
                g.h != e.h || g.v != e.v || g.x != e.x || g.y != e.y) begin
               nfail++;
               $display("FAIL cycle_cmp dut%0d @%0t: got hs%0b vs%0b bl%0b h%0d v%0d x%0d y%0d ls%0b fs%0b, expected hs%0b vs%0b bl%0b h%0d v%0d x%0d y%0d ls%0b fs%0b",
                        e.sel, $time, g.hs, g.vs, g.bl, g.h, g.v, g.x, g.y, g.ls, g.fs,
                        e.hs, e.vs, e.bl, e.h, e.v, e.x, e.y, e.ls, e.fs);
            end
            if (e.win) begin
               if (g.hs == P_HPOL[e.sel]) acc_hs++;
               if (g.vs == P_VPOL[e.sel]) acc_vs++;
               if (g.bl) acc_bl++;
               if (g.ls) acc_ls++;
               if (g.fs) acc_fs++;
               if (g.x > acc_xmax) acc_xmax = g.x;
               if (g.y > acc_ymax) acc_ymax = g.y;
            end
         end
      end
   end

   initial begin
      rst0 = 1'b0; en0 = 1'b0;
      rst1 = 1'b0; en1 = 1'b0;
      rst2 = 1'b0; en2 = 1'b0;
      clr();

      // 640x480: reset with pix_en high, then run down to the first visible line.
      repeat (3) step(0, 1'b0, 1'b1, 1'b0);
      repeat (28000) step(0, 1'b1, 1'b1, 1'b0);
      clr();
      repeat (800) step(0, 1'b1, 1'b1, 1'b1);
      step(0, 1'b1, 1'b1, 1'b0);
      chk("def_hs_low_cycles", acc_hs, 96);
      chk("def_blank_high_cycles", acc_bl, 640);
      chk("def_x_max", acc_xmax, 639);
      chk("def_line_start_count", acc_ls, 1);

      // Half-rate pixel enable: every position is shown for two clocks.
      clr();
      for (int i = 0; i < 1600; i++) step(0, 1'b1, (i % 2) == 0, 1'b1);
      step(0, 1'b1, 1'b1, 1'b0);
      chk("tog_hs_low_cycles", acc_hs, 192);
      chk("tog_blank_high_cycles", acc_bl, 1280);
      chk("tog_line_start_count", acc_ls, 1);

      // Reset in the middle of a line.
      for (int i = 0; i < 1000 && mh[0] != 400; i++) step(0, 1'b1, 1'b1, 1'b0);
      step(0, 1'b0, 1'b1, 1'b0);
      repeat (10) step(0, 1'b1, 1'b1, 1'b0);

      // Tiny raster, combinational outputs: full frames and wraps.
      repeat (3) step(1, 1'b0, 1'b1, 1'b0);
      repeat (10) step(1, 1'b1, 1'b1, 1'b0);
      clr();
      repeat (144) step(1, 1'b1, 1'b1, 1'b1);
      step(1, 1'b1, 1'b1, 1'b0);
      chk("sml_frame_start_count", acc_fs, 1);
      chk("sml_line_start_count", acc_ls, 9);
      chk("sml_vs_low_cycles", acc_vs, 32);
      chk("sml_hs_low_cycles", acc_hs, 18);
      chk("sml_blank_high_cycles", acc_bl, 32);
      chk("sml_x_max", acc_xmax, 7);
      chk("sml_y_max", acc_ymax, 3);
      for (int i = 0; i < 200 && !(mh[1] == 10 && mv[1] == 5); i++) step(1, 1'b1, 1'b1, 1'b0);
      step(1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 300; i++) step(1, 1'b1, (i % 3) != 0, 1'b0);

      // 800x600, positive sync, three-stage delay.
      repeat (3) step(2, 1'b0, 1'b1, 1'b0);
      clr();
      repeat (5280) step(2, 1'b1, 1'b1, 1'b1);
      step(2, 1'b1, 1'b1, 1'b0);
      chk("svga_hs_high_cycles", acc_hs, 640);
      chk("svga_vs_high_cycles", acc_vs, 4224);
      for (int i = 0; i < 30000 && !(mv[2] == 27 && mh[2] == 0); i++) step(2, 1'b1, 1'b1, 1'b0);
      clr();
      repeat (1056) step(2, 1'b1, 1'b1, 1'b1);
      step(2, 1'b1, 1'b1, 1'b0);
      chk("svga_blank_high_cycles", acc_bl, 800);
      chk("svga_x_max", acc_xmax, 799);
      chk("svga_line_start_count", acc_ls, 1);

      repeat (2) @(posedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
